sram_rw_requester: RTL and testbench

- Initiator side of the single-port RW0 SRAM interface used by the cache data arrays (e.g. the 64x32 byte-masked array).
- Accepts a valid/ready request stream and drives the RW0_* port, tracking the 1-cycle macro read latency.
- Read data is captured into a small response FIFO with valid/ready backpressure.
- Sits between the cache pipeline and the array wrapper; RW0_clk is driven from clock at the parent.

---
 rtl/sram_rw_requester_if.sv | 37 +++
 rtl/sram_rw_requester.sv | 202 ++++++++++++++++++++
 tb/tb_sram_rw_requester.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_rw_requester_if.sv
// Request/response/RW0 bundle for the SRAM RW0 requester.
// slave  : the requester's view (takes requests, drives responses and the RW0 port).
// master : the surrounding view (cache pipeline plus array wrapper).
interface sram_rw_requester_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              busy;
    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [MASK_W-1:0] RW0_wmask;
    logic [DATA_W-1:0] RW0_wdata;
    logic [DATA_W-1:0] RW0_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready, RW0_rdata,
        output req_ready, resp_valid, resp_rdata, busy,
               RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready, RW0_rdata,
        input  req_ready, resp_valid, resp_rdata, busy,
               RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
    );
endinterface

// File: rtl/sram_rw_requester.sv
// Initiator for the single-port RW0 SRAM used by the cache data arrays.
// Requests drive RW0 combinationally; read data returns one cycle later and is
// captured into a small response FIFO. Reads are only accepted when the FIFO
// has room for every read still in flight, so the FIFO can never overflow.
// Optional macro SRAM_INIT_EN: after reset, sweep the array writing zeros
// (busy=1, no requests accepted) before entering normal operation.
module sram_rw_requester #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int MASK_W     = 4,
    parameter int RESP_DEPTH = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    sram_rw_requester_if.slave   bus
);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef SRAM_INIT_EN
    localparam logic [1:0] ST_INIT = 2'd1;
`endif
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(RESP_DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR_C = PTR_W'(RESP_DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR_C = {ADDR_W{1'b1}};

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              inflight_r;
    logic [DATA_W-1:0] fifo_mem_r [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  fifo_count_r;
    logic [CNT_W:0]    occupancy_s;
    logic              run_s;
    logic              init_s;
    logic              req_ready_s;
    logic              fire_s;
    logic              read_fire_s;
    logic              push_s;
    logic              pop_s;
    logic              resp_valid_s;
    logic [ADDR_W-1:0] rw0_addr_s;
    logic              rw0_en_s;
    logic              rw0_wmode_s;
    logic [MASK_W-1:0] rw0_wmask_s;
    logic [DATA_W-1:0] rw0_wdata_s;

    // Circular pointer advance for a FIFO whose depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR_C) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

`ifdef SRAM_INIT_EN
    logic [ADDR_W-1:0] init_addr_r;
    assign init_s = (state_r == ST_INIT) && !reset;

    // Sweep address for the post-reset zero fill; restarts from 0 on every reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            init_addr_r <= {ADDR_W{1'b0}};
        end else if (state_r == ST_INIT) begin
            init_addr_r <= init_addr_r + ADDR_W'(1'b1);
        end else begin
            init_addr_r <= init_addr_r;
        end
    end
`else
    assign init_s = 1'b0;
`endif

    // Next-state selection: IDLE leaves on the first cycle out of reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
`ifdef SRAM_INIT_EN
                state_nxt_s = ST_INIT;
`else
                state_nxt_s = ST_RUN;
`endif
            end
`ifdef SRAM_INIT_EN
            ST_INIT: begin
                if (init_addr_r == LAST_ADDR_C) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
`endif
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, held in IDLE while reset is asserted.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Acceptance: writes always go in RUN; reads need room for all outstanding data.
    always_comb begin
        run_s       = (state_r == ST_RUN) && !reset;
        occupancy_s = {1'b0, fifo_count_r} + (CNT_W + 1)'(inflight_r);
        req_ready_s = 1'b0;
        if (run_s) begin
            if (bus.req_write) begin
                req_ready_s = 1'b1;
            end else begin
                req_ready_s = (occupancy_s < {1'b0, DEPTH_C});
            end
        end else begin
            req_ready_s = 1'b0;
        end
        fire_s      = req_ready_s && bus.req_valid;
        read_fire_s = fire_s && !bus.req_write;
    end

    // RW0 port drive: init sweep, accepted request, or fully quiet.
    always_comb begin
        rw0_en_s    = 1'b0;
        rw0_wmode_s = 1'b0;
        rw0_addr_s  = {ADDR_W{1'b0}};
        rw0_wmask_s = {MASK_W{1'b0}};
        rw0_wdata_s = {DATA_W{1'b0}};
`ifdef SRAM_INIT_EN
        if (init_s) begin
            rw0_en_s    = 1'b1;
            rw0_wmode_s = 1'b1;
            rw0_addr_s  = init_addr_r;
            rw0_wmask_s = {MASK_W{1'b1}};
        end else
`endif
        if (fire_s) begin
            rw0_en_s    = 1'b1;
            rw0_wmode_s = bus.req_write;
            rw0_addr_s  = bus.req_addr;
            if (bus.req_write) begin
                rw0_wmask_s = bus.req_wmask;
                rw0_wdata_s = bus.req_wdata;
            end else begin
                rw0_wmask_s = {MASK_W{1'b0}};
                rw0_wdata_s = {DATA_W{1'b0}};
            end
        end else begin
            rw0_en_s = 1'b0;
        end
    end

    // FIFO handshake: capture is unconditional one cycle after a read fires.
    always_comb begin
        resp_valid_s = !reset && (fifo_count_r != {CNT_W{1'b0}});
        push_s       = inflight_r;
        pop_s        = resp_valid_s && bus.resp_ready;
    end

    // In-flight tracking and FIFO pointers/count; reset discards everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_r   <= 1'b0;
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            fifo_count_r <= {CNT_W{1'b0}};
        end else begin
            inflight_r <= read_fire_s;
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= bus.RW0_rdata;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1'b1);
                2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1'b1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = resp_valid_s;
    assign bus.resp_rdata = fifo_mem_r[rd_ptr_r];
    assign bus.busy       = init_s;
    assign bus.RW0_en     = rw0_en_s;
    assign bus.RW0_wmode  = rw0_wmode_s;
    assign bus.RW0_addr   = rw0_addr_s;
    assign bus.RW0_wmask  = rw0_wmask_s;
    assign bus.RW0_wdata  = rw0_wdata_s;
endmodule

// File: tb/tb_sram_rw_requester.sv
// Bench for sram_rw_requester: array model, queue-based reference of the
// request/response behaviour, per-cycle compare, directed and random stimulus.
module tb_sram_rw_requester;
    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 32;
    localparam int MASK_W     = 4;
    localparam int RESP_DEPTH = 3;
    localparam int N          = 1 << ADDR_W;
    localparam int LANE_W     = DATA_W / MASK_W;
`ifdef SRAM_INIT_EN
    localparam logic [DATA_W-1:0] FILL = 32'hFFFF_FFFF;
`else
    localparam logic [DATA_W-1:0] FILL = 32'h0000_0000;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    sram_rw_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

    sram_rw_requester #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Array macro: sequential, byte-lane write mask, read data the next cycle.
    logic [DATA_W-1:0] sram_mem [N];
    initial begin
        for (int i = 0; i < N; i++) sram_mem[i] <= FILL;
        bus.RW0_rdata <= 32'h0;
        forever begin
            @(posedge clock);
            if (bus.RW0_en) begin
                if (bus.RW0_wmode) begin
                    for (int l = 0; l < MASK_W; l++)
                        if (bus.RW0_wmask[l])
                            sram_mem[bus.RW0_addr][l*LANE_W +: LANE_W] <= bus.RW0_wdata[l*LANE_W +: LANE_W];
                end else begin
                    bus.RW0_rdata <= sram_mem[bus.RW0_addr];
                end
            end
        end
    end

    // Reference: memory image, ordered queue of outstanding reads with due cycle.
    logic [DATA_W-1:0] ref_mem [N];
    logic [DATA_W-1:0] exp_q [$];
    int                due_q [$];
    int                cyc     = 0;
    int                phase   = 0;
    bit                started = 1'b0;

    function automatic bit m_init();
`ifdef SRAM_INIT_EN
        return !reset && phase >= 1 && phase <= N;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_run();
`ifdef SRAM_INIT_EN
        return !reset && phase > N;
`else
        return !reset && phase >= 1;
`endif
    endfunction

    function automatic bit m_ready();
        return m_run() && (bus.req_write || exp_q.size() < RESP_DEPTH);
    endfunction

    function automatic bit m_resp_valid();
        return !reset && exp_q.size() > 0 && due_q[0] <= cyc;
    endfunction

    // Reference update at each active edge, from pre-edge state and inputs.
    initial begin
        bit fire_m;
        bit pop_m;
        for (int i = 0; i < N; i++) ref_mem[i] = FILL;
        forever begin
            @(posedge clock);
            if (reset) begin
                exp_q.delete();
                due_q.delete();
                phase = 0;
            end else begin
                fire_m = m_ready() && bus.req_valid;
                pop_m  = m_resp_valid() && bus.resp_ready;
                if (pop_m) begin
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
                if (m_init()) begin
                    ref_mem[phase-1] = 32'h0;
                end else if (fire_m && bus.req_write) begin
                    for (int l = 0; l < MASK_W; l++)
                        if (bus.req_wmask[l])
                            ref_mem[bus.req_addr][l*LANE_W +: LANE_W] = bus.req_wdata[l*LANE_W +: LANE_W];
                end else if (fire_m) begin
                    exp_q.push_back(ref_mem[bus.req_addr]);
                    due_q.push_back(cyc + 2);
                end
                phase++;
            end
            cyc++;
            started = 1'b1;
        end
    end

    // Per-cycle compare of every DUT output against the reference.
    initial begin
        logic              e_en, e_wm;
        logic [ADDR_W-1:0] e_addr;
        logic [MASK_W-1:0] e_mask;
        logic [DATA_W-1:0] e_data;
        forever begin
            @(negedge clock);
            if (started) begin
                e_en = 1'b0; e_wm = 1'b0; e_addr = '0; e_mask = '0; e_data = '0;
                if (m_init()) begin
                    e_en = 1'b1; e_wm = 1'b1; e_addr = ADDR_W'(phase - 1); e_mask = {MASK_W{1'b1}};
                end else if (m_ready() && bus.req_valid) begin
                    e_en = 1'b1; e_wm = bus.req_write; e_addr = bus.req_addr;
                    if (bus.req_write) begin
                        e_mask = bus.req_wmask;
                        e_data = bus.req_wdata;
                    end
                end
                chk("req_ready", 64'(bus.req_ready), 64'(m_ready()));
                chk("busy", 64'(bus.busy), 64'(m_init()));
                chk("RW0_en", 64'(bus.RW0_en), 64'(e_en));
                chk("RW0_wmode", 64'(bus.RW0_wmode), 64'(e_wm));
                chk("RW0_addr", 64'(bus.RW0_addr), 64'(e_addr));
                chk("RW0_wmask", 64'(bus.RW0_wmask), 64'(e_mask));
                chk("RW0_wdata", 64'(bus.RW0_wdata), 64'(e_data));
                chk("resp_valid", 64'(bus.resp_valid), 64'(m_resp_valid()));
                if (m_resp_valid()) chk("resp_rdata", 64'(bus.resp_rdata), 64'(exp_q[0]));
                chk("fifo_bound", 64'(dut.fifo_count_r <= RESP_DEPTH), 64'd1);
            end
        end
    end

    task automatic do_req(input logic w, input int a, input logic [31:0] d,
                          input logic [3:0] m, output int waited);
        bit fired = 1'b0;
        waited = 0;
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = ADDR_W'(a);
        bus.req_wdata = d; bus.req_wmask = m;
        for (int k = 0; k < 200 && !fired; k++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                fired = 1'b1;
                chk("req_RW0_en", 64'(bus.RW0_en), 64'd1);
                chk("req_RW0_wmode", 64'(bus.RW0_wmode), 64'(w));
            end else begin
                waited++;
            end
            tick();
        end
        bus.req_valid = 1'b0;
        if (!fired) chk("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic expect_resp(input string name, input logic [31:0] lit);
        bit got = 1'b0;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                got = 1'b1;
                chk(name, 64'(bus.resp_rdata), 64'(lit));
            end
            tick();
        end
        if (!got) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int accepted;
        int busy_cnt;
        bus.req_valid = 1'b0; bus.req_write = 1'b1; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wmask = '0; bus.resp_ready = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ready", 64'(bus.req_ready), 64'd0);
        tick();

`ifdef SRAM_INIT_EN
        busy_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus.busy) busy_cnt++;
            tick();
        end
        chk("init_busy_cycles", 64'(busy_cnt), 64'd64);
        do_req(1'b0, 0, 32'h0, 4'h0, w);  expect_resp("init_rd0", 32'h0);
        do_req(1'b0, 31, 32'h0, 4'h0, w); expect_resp("init_rd31", 32'h0);
        do_req(1'b0, 63, 32'h0, 4'h0, w); expect_resp("init_rd63", 32'h0);
`endif

        // Write then read back with exact two-edge latency.
        do_req(1'b1, 5, 32'hDEADBEEF, 4'hF, w);
        do_req(1'b0, 5, 32'h0, 4'h0, w);
        @(negedge clock); chk("lat_edge1_valid", 64'(bus.resp_valid), 64'd0);
        tick();
        @(negedge clock); chk("lat_edge2_valid", 64'(bus.resp_valid), 64'd1);
        chk("raw_data", 64'(bus.resp_rdata), 64'h0000_0000_DEAD_BEEF);
        tick();

        // Partial-mask merge.
        do_req(1'b1, 7, 32'h11223344, 4'hF, w);
        do_req(1'b1, 7, 32'hAABBCCDD, 4'h5, w);
        do_req(1'b0, 7, 32'h0, 4'h0, w);
        expect_resp("mask_merge", 32'h11BB33DD);

        // Back-to-back reads of 0..9 with the consumer always ready.
        for (int i = 0; i < 10; i++) do_req(1'b1, i, 32'hA000_0000 + 32'(i), 4'hF, w);
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = (i < 10); bus.req_write = 1'b0; bus.req_addr = ADDR_W'(i % 10);
            @(negedge clock);
            if (i < 10) chk("burst_ready", 64'(bus.req_ready), 64'd1);
            if (i >= 2) begin
                chk("burst_valid", 64'(bus.resp_valid), 64'd1);
                chk("burst_data", 64'(bus.resp_rdata), 64'(32'hA000_0000 + 32'(i - 2)));
            end
            tick();
        end
        bus.req_valid = 1'b0;

        // Backpressure: three reads accepted, then writes still flow.
        bus.resp_ready = 1'b0;
        accepted = 0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = ADDR_W'(0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus.req_ready) accepted++;
            tick();
        end
        chk("bp_accepts", 64'(accepted), 64'd3);
        do_req(1'b1, 20, 32'h5555AAAA, 4'hF, w);
        chk("bp_write_immediate", 64'(w), 64'd0);
        expect_resp("bp_resp0", 32'hA000_0000);
        expect_resp("bp_resp1", 32'hA000_0000);
        expect_resp("bp_resp2", 32'hA000_0000);

        // Write with empty mask: issued, silent, leaves data intact.
        do_req(1'b1, 3, 32'h12345678, 4'hF, w);
        do_req(1'b1, 3, 32'hFFFFFFFF, 4'h0, w);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); chk("mask0_noresp", 64'(bus.resp_valid), 64'd0);
            tick();
        end
        do_req(1'b0, 3, 32'h0, 4'h0, w);
        expect_resp("mask0_data", 32'h12345678);

        // Reset the cycle after a read fires: nothing may come out afterwards.
        do_req(1'b0, 5, 32'h0, 4'h0, w);
        reset = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = ADDR_W'(5);
        @(negedge clock);
        chk("rst_RW0_en", 64'(bus.RW0_en), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        tick();
        reset = 1'b0; bus.req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock); chk("post_rst_valid", 64'(bus.resp_valid), 64'd0);
            tick();
        end

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            reset          = ($urandom_range(0, 299) == 0);
            bus.req_valid  = ($urandom_range(0, 3) != 0);
            bus.req_write  = $urandom_range(0, 1) != 0;
            bus.req_addr   = ADDR_W'($urandom_range(0, 15));
            bus.req_wdata  = $urandom;
            bus.req_wmask  = MASK_W'($urandom_range(0, 15));
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0; bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
